uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares the single `uart_tx` serializer between up to `NUM_REQ` byte-stream requesters, such as the print controller, the RX echo path and status reporters. Each requester presents packets as valid/ready byte streams terminated by `last`. The grant is held for a whole packet, so characters from different sources never interleave on `txp`. The block sits between the requesters and `uart_tx` inside `top`.

---
 rtl/uart_arb_pkg.sv | 18 +
 rtl/rr_pick.sv | 39 +++
 rtl/uart_tx_arbiter.sv | 161 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg
// Shared definitions for the UART transmit arbiter.
//   arb_state_e        : arbiter state encoding (ARB_IDLE / ARB_BUSY)
//   arb_timeout_limit  : mid-packet stall limit in clock cycles
package uart_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    // Stall limit in cycles: clock in MHz times timeout in microseconds.
    function automatic int unsigned arb_timeout_limit(input int unsigned clk_fre_mhz,
                                                      input int unsigned timeout_us);
        return clk_fre_mhz * timeout_us;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick
// Combinational round-robin picker. Searches req starting at ptr+1 and
// wrapping modulo NUM_REQ; the first asserted request wins.
// Ports:
//   req      in  NUM_REQ  request vector
//   ptr      in  IDX_W    index of the previous winner
//   pick     out NUM_REQ  one-hot winner (0 when req is 0)
//   pick_idx out IDX_W    binary index of the winner (0 when req is 0)
module rr_pick #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic [IDX_W-1:0]   pick_idx
);

    always_comb begin
        logic             found;
        int               idx;
        logic [IDX_W-1:0] idx_w;
        pick     = '0;
        pick_idx = '0;
        found    = 1'b0;
        idx      = 0;
        idx_w    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx   = (int'(ptr) + k) % NUM_REQ;
            idx_w = IDX_W'(idx);
            if (!found && req[idx_w]) begin
                found       = 1'b1;
                pick[idx_w] = 1'b1;
                pick_idx    = idx_w;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin arbiter sharing one uart_tx serializer between NUM_REQ byte
// streams. A grant is held for a whole packet (through the byte with last),
// so bytes from different sources never interleave.
// Optional feature macro: UART_ARB_TIMEOUT_EN -- releases a grant whose owner
// stalls (valid low) for CLK_FRE*TIMEOUT_US cycles mid-packet.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   req_valid/data/last, req_ready   per-requester byte streams
//   tx_data/tx_valid/tx_ready        stream to uart_tx
//   grant           one-hot owner, 0 when idle
//   busy            packet in progress (|grant)
//   timeout_pulse   one-cycle pulse on forced release
//
// state    | meaning
// ---------+---------------------------------------------------------
// ARB_IDLE | no owner; picks next requester round-robin from ptr+1
// ARB_BUSY | owner gidx passes bytes straight through until last
module uart_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int CLK_FRE    = 27,
    parameter int TIMEOUT_US = 1000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic                 timeout_pulse
);
    import uart_arb_pkg::*;

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   gidx_q, gidx_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;

    logic [NUM_REQ-1:0] pick;
    logic [IDX_W-1:0]   pick_idx;
    logic               hs;
    logic               last_hs;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned STALL_LIMIT = arb_timeout_limit(CLK_FRE, TIMEOUT_US);
    localparam int          STALL_W     = $clog2(STALL_LIMIT + 1);
    // Counter holds the number of stalled cycles already completed, so the
    // release fires on the stalled cycle that would complete the limit.
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_LIMIT - 1);

    logic [STALL_W-1:0] stall_q, stall_d;
    logic               timeout_pulse_q, timeout_pulse_d;
`endif

    rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
        .req      (req_valid),
        .ptr      (ptr_q),
        .pick     (pick),
        .pick_idx (pick_idx)
    );

    // Pass-through mux driven only by the registered grant index.
    always_comb begin
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        req_ready = '0;
        if (state_q == ARB_BUSY) begin
            tx_valid          = req_valid[gidx_q];
            tx_data           = req_data[{gidx_q, 3'b000} +: 8];
            req_ready[gidx_q] = tx_ready;
        end
    end

    assign hs      = tx_valid & tx_ready;
    assign last_hs = hs & req_last[gidx_q];
    assign grant   = grant_q;
    assign busy    = |grant_q;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
`ifdef UART_ARB_TIMEOUT_EN
        stall_d         = stall_q;
        timeout_pulse_d = 1'b0;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (|req_valid) begin
                    state_d = ARB_BUSY;
                    grant_d = pick;
                    gidx_d  = pick_idx;
`ifdef UART_ARB_TIMEOUT_EN
                    stall_d = '0;
`endif
                end
            end
            ARB_BUSY: begin
                if (last_hs) begin
                    state_d = ARB_IDLE;
                    grant_d = '0;
                    ptr_d   = gidx_q;
                end
`ifdef UART_ARB_TIMEOUT_EN
                // A handshake always wins over the stall limit.
                if (hs) begin
                    stall_d = '0;
                end else if (!req_valid[gidx_q]) begin
                    if (stall_q == STALL_LAST) begin
                        state_d         = ARB_IDLE;
                        grant_d         = '0;
                        ptr_d           = gidx_q;
                        stall_d         = '0;
                        timeout_pulse_d = 1'b1;
                    end else begin
                        stall_d = stall_q + 1'b1;
                    end
                end
`endif
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= IDX_W'(NUM_REQ - 1);
`ifdef UART_ARB_TIMEOUT_EN
            stall_q         <= '0;
            timeout_pulse_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
`ifdef UART_ARB_TIMEOUT_EN
            stall_q         <= stall_d;
            timeout_pulse_q <= timeout_pulse_d;
`endif
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    assign timeout_pulse = timeout_pulse_q;
`else
    assign timeout_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
    localparam int NUM_REQ = 4;
`ifdef UART_ARB_TIMEOUT_EN
    localparam int CLK_FRE    = 1;
    localparam int TIMEOUT_US = 20;
`else
    localparam int CLK_FRE    = 27;
    localparam int TIMEOUT_US = 1000;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*8-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [7:0]           tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [NUM_REQ-1:0]   grant;
    logic                 busy;
    logic                 timeout_pulse;

    logic       v_drv [NUM_REQ];
    logic       l_drv [NUM_REQ];
    logic [7:0] d_drv [NUM_REQ];

    typedef struct packed {
        logic [7:0] src;
        logic [7:0] data;
    } exp_t;
    exp_t exp_q[$];

    int errors = 0;
    int checks = 0;

    uart_tx_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .CLK_FRE    (CLK_FRE),
        .TIMEOUT_US (TIMEOUT_US)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .grant         (grant),
        .busy          (busy),
        .timeout_pulse (timeout_pulse)
    );

    always #5 clk = ~clk;

    always_comb begin
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i]       = v_drv[i];
            req_last[i]        = l_drv[i];
            req_data[i*8 +: 8] = d_drv[i];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int src, input logic [7:0] data);
        exp_t e;
        e.src  = 8'(src);
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: every accepted byte is compared with the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got byte %0h from grant %0h, expected none", tx_data, grant);
            end else begin
                e = exp_q.pop_front();
                check("sb_data", {24'b0, tx_data}, {24'b0, e.data});
                check("sb_grant", {28'b0, grant}, 32'(1) << e.src);
            end
        end
    end

    // Called at posedge+1; drives one packet, optionally dropping valid for
    // stall_cyc cycles before byte index stall_at.
    task automatic send_pkt(input int src, input int len, input logic [7:0] base,
                            input int stall_at, input int stall_cyc);
        for (int k = 0; k < len; k++) begin
            int n;
            if (k == stall_at) begin
                v_drv[src] = 1'b0;
                repeat (stall_cyc) @(posedge clk);
                #1;
            end
            v_drv[src] = 1'b1;
            d_drv[src] = base + 8'(k);
            l_drv[src] = (k == len - 1);
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!req_ready[src] && n < 400);
            if (!req_ready[src]) begin
                checks++;
                errors++;
                $display("FAIL hs_timeout: src %0d byte %0d got no ready, expected ready within 400 cycles", src, k);
            end
            @(posedge clk);
            #1;
        end
        v_drv[src] = 1'b0;
        l_drv[src] = 1'b0;
    endtask

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_grant"},     {28'b0, grant},     32'h0);
        check({tag, "_busy"},      {31'b0, busy},      32'h0);
        check({tag, "_tx_valid"},  {31'b0, tx_valid},  32'h0);
        check({tag, "_tx_data"},   {24'b0, tx_data},   32'h0);
        check({tag, "_req_ready"}, {28'b0, req_ready}, 32'h0);
        check({tag, "_tpulse"},    {31'b0, timeout_pulse}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

    initial begin
        logic [3:0] exp_g [13];
        exp_g = '{4'h0, 4'h1, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0};

        for (int i = 0; i < NUM_REQ; i++) begin
            v_drv[i] = 1'b0;
            l_drv[i] = 1'b0;
            d_drv[i] = 8'h00;
        end
        tx_ready = 1'b1;
        rst_n    = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        @(negedge clk);
        check_reset_outputs("rst");
        align();
        rst_n = 1'b1;

        // Single packet 'A','B','C' from requester 1
        push_exp(1, 8'h41);
        push_exp(1, 8'h42);
        push_exp(1, 8'h43);
        fork
            send_pkt(1, 3, 8'h41, -1, 0);
            begin
                @(negedge clk);
                check("t1_grant_idle", {28'b0, grant}, 32'h0);
                @(negedge clk);
                check("t1_grant", {28'b0, grant}, 32'h2);
                check("t1_byte0", {24'b0, tx_data}, 32'h41);
                @(negedge clk);
                check("t1_byte1", {24'b0, tx_data}, 32'h42);
                @(negedge clk);
                check("t1_byte2", {24'b0, tx_data}, 32'h43);
                @(negedge clk);
                check("t1_busy_drop", {31'b0, busy}, 32'h0);
            end
        join
        align();

        // Round-robin order from reset: 0,2,3,0,2,3 with one idle bubble each
        rst_n = 1'b0;
        align();
        rst_n = 1'b1;
        push_exp(0, 8'hA0);
        push_exp(2, 8'hC0);
        push_exp(3, 8'hD0);
        push_exp(0, 8'hA1);
        push_exp(2, 8'hC1);
        push_exp(3, 8'hD1);
        fork
            begin send_pkt(0, 1, 8'hA0, -1, 0); send_pkt(0, 1, 8'hA1, -1, 0); end
            begin send_pkt(2, 1, 8'hC0, -1, 0); send_pkt(2, 1, 8'hC1, -1, 0); end
            begin send_pkt(3, 1, 8'hD0, -1, 0); send_pkt(3, 1, 8'hD1, -1, 0); end
            begin
                for (int c = 0; c < 13; c++) begin
                    @(negedge clk);
                    check($sformatf("t2_grant_c%0d", c), {28'b0, grant}, {28'b0, exp_g[c]});
                end
            end
        join
        align();

        // Backpressure mid-packet, requester 2 competing
        push_exp(0, 8'hB0);
        push_exp(0, 8'hB1);
        push_exp(0, 8'hB2);
        push_exp(0, 8'hB3);
        push_exp(2, 8'hE0);
        fork
            send_pkt(0, 4, 8'hB0, -1, 0);
            send_pkt(2, 1, 8'hE0, -1, 0);
            begin
                repeat (3) @(negedge clk);
                align();
                tx_ready = 1'b0;
                for (int c = 0; c < 10; c++) begin
                    @(negedge clk);
                    check("t3_ready_low", {28'b0, req_ready}, 32'h0);
                    check("t3_data_held", {24'b0, tx_data}, 32'hB2);
                    check("t3_grant", {28'b0, grant}, 32'h1);
                end
                align();
                tx_ready = 1'b1;
            end
        join
        align();

`ifndef UART_ARB_TIMEOUT_EN
        // Valid drop for 50 cycles after byte 2 of 4: grant is held
        push_exp(0, 8'h90);
        push_exp(0, 8'h91);
        push_exp(0, 8'h92);
        push_exp(0, 8'h93);
        fork
            send_pkt(0, 4, 8'h90, 2, 50);
            begin
                repeat (3) @(negedge clk);
                for (int c = 0; c < 50; c++) begin
                    @(negedge clk);
                    check("t4_grant_held", {28'b0, grant}, 32'h1);
                    check("t4_tx_valid", {31'b0, tx_valid}, 32'h0);
                end
            end
        join
        @(negedge clk);
        check("t4_release", {28'b0, grant}, 32'h0);
        align();
`else
        // Stall timeout: requester 1 stalls after 2 bytes, requester 2 waits
        push_exp(1, 8'h60);
        push_exp(1, 8'h61);
        push_exp(2, 8'hE8);
        push_exp(1, 8'h62);
        push_exp(1, 8'h63);
        fork
            send_pkt(1, 4, 8'h60, 2, 40);
            send_pkt(2, 1, 8'hE8, -1, 0);
            begin
                repeat (3) @(negedge clk);
                for (int c = 0; c < 20; c++) begin
                    @(negedge clk);
                    check("t5_no_pulse", {31'b0, timeout_pulse}, 32'h0);
                    check("t5_grant_held", {28'b0, grant}, 32'h2);
                end
                @(negedge clk);
                check("t5_pulse", {31'b0, timeout_pulse}, 32'h1);
                check("t5_released", {28'b0, grant}, 32'h0);
                @(negedge clk);
                check("t5_pulse_end", {31'b0, timeout_pulse}, 32'h0);
                check("t5_grant_next", {28'b0, grant}, 32'h4);
            end
        join
        align();
`endif

        // Reset mid-packet
        tx_ready = 1'b0;
        v_drv[3] = 1'b1;
        d_drv[3] = 8'h77;
        l_drv[3] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t6_grant_pre", {28'b0, grant}, 32'h8);
        align();
        v_drv[0] = 1'b1;
        d_drv[0] = 8'h55;
        l_drv[0] = 1'b1;
        rst_n    = 1'b0;
        align();
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("t6");
        align();
        tx_ready = 1'b1;
        push_exp(0, 8'h55);
        @(negedge clk);
        check("t6_grant_after", {28'b0, grant}, 32'h1);
        align();
        for (int i = 0; i < NUM_REQ; i++) begin
            v_drv[i] = 1'b0;
            l_drv[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        check("end_busy", {31'b0, busy}, 32'h0);
        check("end_sb_empty", 32'(exp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
